// File: rtl/axi_memory_slave_burst.sv
// -----------------------------------------------------------------------------
// axi_memory_slave_burst
// AXI4 burst responder backed by an internal word-addressed memory array.
// The write channels (AW/W/B) and the read channels (AR/R) are two independent
// state machines that share one memory array.
//
// Ports
//   clk, resetn                      clock, asynchronous active-low reset
//   aw*/awvalid/awready              write burst request
//   wdata/wstrb/wlast/wvalid/wready  write data beats
//   bresp/bvalid/bready              write response
//   ar*/arvalid/arready              read burst request
//   rdata/rresp/rlast/rvalid/rready  read data beats
//
// Bursts: FIXED holds the address, INCR steps one word per beat, and WRAP or
// reserved types step like INCR but answer SLVERR. A beat size other than the
// full bus width also answers SLVERR; such writes are dropped and reads
// return zero. Beats outside the array are dropped/zero and answer SLVERR.
// -----------------------------------------------------------------------------
module axi_memory_slave_burst #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 128
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int SIZE_LOG2 = $clog2(STRB_W);
    localparam int IDX_W     = ADDR_WIDTH - SIZE_LOG2;
    localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [2:0]       SIZE_CODE   = 3'(SIZE_LOG2);
    localparam logic [IDX_W-1:0] DEPTH_IDX   = IDX_W'(MEM_DEPTH);
    localparam logic [1:0]       BURST_FIXED = 2'b00;
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    localparam logic [1:0] WR_IDLE = 2'd0;
    localparam logic [1:0] WR_DATA = 2'd1;
    localparam logic [1:0] WR_RESP = 2'd2;
    localparam logic       RD_IDLE = 1'b0;
    localparam logic       RD_DATA = 1'b1;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Sub-word address bits never select anything: beats are always full width.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{awaddr[SIZE_LOG2-1:0], araddr[SIZE_LOG2-1:0]};

    // ------------------------------------------------------------------ write
    logic [1:0]       r_wstate;
    logic [IDX_W-1:0] r_widx;
    logic [7:0]       r_wlen;
    logic [7:0]       r_wcnt;
    logic             r_wfixed;
    logic             r_wlegal;
    logic             r_werr;
    logic [1:0]       r_bresp;

    logic w_aw_legal;
    logic w_wbeat;
    logic w_win_range;
    logic w_wlast_beat;
    logic w_wbeat_err;
    logic w_wr_en;

    assign awready = (r_wstate == WR_IDLE);
    assign wready  = (r_wstate == WR_DATA);
    assign bvalid  = (r_wstate == WR_RESP);
    assign bresp   = r_bresp;

    assign w_aw_legal   = !awburst[1] && (awsize == SIZE_CODE);
    assign w_wbeat      = wvalid && wready;
    assign w_win_range  = (r_widx < DEPTH_IDX);
    assign w_wlast_beat = (r_wcnt == r_wlen);
    // A beat is faulty if it falls outside the array or its wlast disagrees
    // with the awlen-derived position; awlen alone decides where the burst ends.
    assign w_wbeat_err  = !w_win_range || (wlast != w_wlast_beat);
    assign w_wr_en      = w_wbeat && r_wlegal && w_win_range;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wstate <= WR_IDLE;
            r_widx   <= '0;
            r_wlen   <= '0;
            r_wcnt   <= '0;
            r_wfixed <= 1'b0;
            r_wlegal <= 1'b0;
            r_werr   <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else begin
            case (r_wstate)
                WR_IDLE: begin
                    if (awvalid) begin
                        r_widx   <= awaddr[ADDR_WIDTH-1:SIZE_LOG2];
                        r_wlen   <= awlen;
                        r_wcnt   <= 8'd0;
                        r_wfixed <= (awburst == BURST_FIXED);
                        r_wlegal <= w_aw_legal;
                        r_werr   <= !w_aw_legal;
                        r_wstate <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_wbeat) begin
                        if (!r_wfixed) begin
                            r_widx <= r_widx + IDX_W'(1);
                        end
                        r_wcnt <= r_wcnt + 8'd1;
                        if (w_wlast_beat) begin
                            r_bresp  <= (r_werr || w_wbeat_err) ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= WR_RESP;
                        end else begin
                            r_werr <= r_werr || w_wbeat_err;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        r_bresp  <= RESP_OKAY;
                        r_wstate <= WR_IDLE;
                    end
                end
                default: r_wstate <= WR_IDLE;
            endcase
        end
    end

    // NOTE: the memory array has no reset branch; clearing it would force a
    // flop-based array and its contents are undefined after power-up anyway.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    r_mem[r_widx[MEM_AW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------- read
    logic             r_rstate;
    logic [IDX_W-1:0] r_ridx;
    logic [7:0]       r_rlen;
    logic [7:0]       r_rcnt;
    logic             r_rfixed;
    logic             r_rlegal;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]       r_rresp;
    logic             r_rlast;

    logic [IDX_W-1:0]      w_ar_idx;
    logic                  w_ar_legal;
    logic [IDX_W-1:0]      w_rsrc_idx;
    logic                  w_rsrc_ok;
    logic [DATA_WIDTH-1:0] w_rsrc_data;
    logic                  w_rbeat;

    assign arready = (r_rstate == RD_IDLE);
    assign rvalid  = (r_rstate == RD_DATA);
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rlast   = r_rlast;

    assign w_ar_idx   = araddr[ADDR_WIDTH-1:SIZE_LOG2];
    assign w_ar_legal = !arburst[1] && (arsize == SIZE_CODE);

    // One lookup serves both the first beat (straight from the AR channel)
    // and every following beat (from the stepped burst address).
    assign w_rsrc_idx  = (r_rstate == RD_IDLE) ? w_ar_idx : r_ridx;
    assign w_rsrc_ok   = ((r_rstate == RD_IDLE) ? w_ar_legal : r_rlegal)
                         && (w_rsrc_idx < DEPTH_IDX);
    assign w_rsrc_data = w_rsrc_ok ? r_mem[w_rsrc_idx[MEM_AW-1:0]] : '0;
    assign w_rbeat     = rvalid && rready;

    // NOTE: non-blocking updates here and in the memory process mean a read
    // of a word written on the same edge captures the previous contents.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rstate <= RD_IDLE;
            r_ridx   <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_rfixed <= 1'b0;
            r_rlegal <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
            r_rlast  <= 1'b0;
        end else if (r_rstate == RD_IDLE) begin
            if (arvalid) begin
                r_ridx   <= (arburst == BURST_FIXED) ? w_ar_idx : w_ar_idx + IDX_W'(1);
                r_rlen   <= arlen;
                r_rcnt   <= 8'd1;
                r_rfixed <= (arburst == BURST_FIXED);
                r_rlegal <= w_ar_legal;
                r_rdata  <= w_rsrc_data;
                r_rresp  <= w_rsrc_ok ? RESP_OKAY : RESP_SLVERR;
                r_rlast  <= (arlen == 8'd0);
                r_rstate <= RD_DATA;
            end
        end else if (w_rbeat) begin
            if (r_rlast) begin
                r_rlast  <= 1'b0;
                r_rstate <= RD_IDLE;
            end else begin
                r_rdata <= w_rsrc_data;
                r_rresp <= w_rsrc_ok ? RESP_OKAY : RESP_SLVERR;
                r_rlast <= (r_rcnt == r_rlen);
                r_rcnt  <= r_rcnt + 8'd1;
                if (!r_rfixed) begin
                    r_ridx <= r_ridx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_memory_slave_burst.sv
// -----------------------------------------------------------------------------
// tb_axi_memory_slave_burst
// Directed and randomized bursts against axi_memory_slave_burst. A plain word
// array models the memory; expected data and responses are computed per beat
// from the start address, burst type, size and strobes.
// -----------------------------------------------------------------------------
module tb_axi_memory_slave_burst;

    logic        clk;
    logic        resetn;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    axi_memory_slave_burst dut (
        .clk(clk), .resetn(resetn),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [128];
    logic [31:0] wbuf [256];
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte address of beat i; everything except FIXED steps one word per beat.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
        return (burst == 2'b00) ? a : a + 32'(4 * i);
    endfunction

    function automatic bit beat_ok(input logic [31:0] a, input logic [1:0] burst, input logic [2:0] size);
        return !burst[1] && (size == 3'd2) && ((a >> 2) < 32'd128);
    endfunction

    // abort_at >= 0 pulses reset while that beat is offered (beats are numbered from 0).
    task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input logic [2:0] size, input logic [3:0] strb, input bit rand_strb,
                             input int bad_wlast, input int bready_delay, input int abort_at,
                             input string tag);
        int          t;
        logic [1:0]  exp_resp;
        logic [31:0] a;
        logic [3:0]  s;
        exp_resp = 2'b00;
        awaddr = addr; awlen = len[7:0]; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin tick(); t++; end
        check({tag, ":awready"}, 32'(awready), 32'd1);
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(3) == 0) begin
                wvalid = 1'b0;
                tick();
            end
            s = rand_strb ? 4'($urandom) : strb;
            wdata = wbuf[i]; wstrb = s; wlast = (i == len) ^ (i == bad_wlast); wvalid = 1'b1;
            if (i == abort_at) begin
                #2 resetn = 1'b0;
                #1;
                check({tag, ":wready_in_reset"}, 32'(wready), 32'd0);
                check({tag, ":bvalid_in_reset"}, 32'(bvalid), 32'd0);
                wvalid = 1'b0; wlast = 1'b0;
                tick();
                resetn = 1'b1;
                tick();
                check({tag, ":awready_after_reset"}, 32'(awready), 32'd1);
                return;
            end
            t = 0;
            while (!wready && t < 50) begin tick(); t++; end
            check({tag, ":wready"}, 32'(wready), 32'd1);
            tick();
            a = beat_addr(addr, burst, i);
            if (!beat_ok(a, burst, size) || (wlast != (i == len))) exp_resp = 2'b10;
            if (beat_ok(a, burst, size)) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) model_mem[a >> 2][8*b +: 8] = wbuf[i][8*b +: 8];
                end
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        check({tag, ":bvalid_after_last"}, 32'(bvalid), 32'd1);
        check({tag, ":wready_after_last"}, 32'(wready), 32'd0);
        bready = 1'b0;
        for (int d = 0; d < bready_delay; d++) begin
            tick();
            check({tag, ":bvalid_held"}, 32'(bvalid), 32'd1);
            check({tag, ":awready_blocked"}, 32'(awready), 32'd0);
        end
        check({tag, ":bresp"}, 32'(bresp), 32'(exp_resp));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check({tag, ":bvalid_cleared"}, 32'(bvalid), 32'd0);
        check({tag, ":awready_back"}, 32'(awready), 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [2:0] size, input int stall_max, input string tag);
        int          t;
        int          stall;
        logic [31:0] a;
        logic [31:0] exp_data;
        araddr = addr; arlen = len[7:0]; arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin tick(); t++; end
        check({tag, ":arready"}, 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, burst, i);
            exp_data = beat_ok(a, burst, size) ? model_mem[a >> 2] : 32'd0;
            t = 0;
            while (!rvalid && t < 50) begin tick(); t++; end
            check({tag, ":rvalid"}, 32'(rvalid), 32'd1);
            stall = $urandom_range(stall_max);
            if (stall > 0) begin
                rready = 1'b0;
                for (int k = 0; k < stall; k++) begin
                    tick();
                    check({tag, ":rdata_held"}, rdata, exp_data);
                end
            end
            check({tag, ":rdata"}, rdata, exp_data);
            check({tag, ":rresp"}, 32'(rresp), beat_ok(a, burst, size) ? 32'd0 : 32'd2);
            check({tag, ":rlast"}, 32'(rlast), 32'(i == len));
            last_rdata = rdata;
            rready = 1'b1;
            tick();
        end
        rready = 1'b0;
        check({tag, ":rvalid_cleared"}, 32'(rvalid), 32'd0);
        check({tag, ":rlast_cleared"}, 32'(rlast), 32'd0);
        check({tag, ":arready_back"}, 32'(arready), 32'd1);
    endtask

    logic [31:0] r_addr;
    int          r_len;
    int          r_pick;
    logic [1:0]  r_burst;

    initial begin
        resetn = 1'b1;
        awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
        last_rdata = '0;
        for (int i = 0; i < 128; i++) model_mem[i] = '0;
        #2 resetn = 1'b0;
        tick();
        check("rst:awready", 32'(awready), 32'd1);
        check("rst:arready", 32'(arready), 32'd1);
        check("rst:wready", 32'(wready), 32'd0);
        check("rst:bvalid", 32'(bvalid), 32'd0);
        check("rst:rvalid", 32'(rvalid), 32'd0);
        check("rst:rlast", 32'(rlast), 32'd0);
        check("rst:bresp", 32'(bresp), 32'd0);
        check("rst:rresp", 32'(rresp), 32'd0);
        check("rst:rdata", rdata, 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // Clear the whole array with one 128-beat burst so every later read is defined.
        for (int i = 0; i < 256; i++) wbuf[i] = '0;
        axi_write(32'h0, 127, 2'b01, 3'd2, 4'hF, 1'b0, -1, 0, -1, "fill");

        for (int i = 0; i < 8; i++) wbuf[i] = 32'(10 + i);
        axi_write(32'h0, 7, 2'b01, 3'd2, 4'hF, 1'b0, -1, 0, -1, "incr_wr");
        axi_read(32'h0, 7, 2'b01, 3'd2, 0, "incr_rd");

        wbuf[0] = 32'h0;
        axi_write(32'h4, 0, 2'b01, 3'd2, 4'hF, 1'b0, -1, 0, -1, "strb_clr");
        wbuf[0] = 32'hAABBCCDD;
        axi_write(32'h4, 0, 2'b01, 3'd2, 4'b0101, 1'b0, -1, 0, -1, "strb_wr");
        axi_read(32'h4, 0, 2'b01, 3'd2, 0, "strb_rd");
        check("strb_value", last_rdata, 32'h00BB00DD);

        axi_read(32'h20, 3, 2'b01, 3'd2, 2, "stall_rd");
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
        axi_write(32'h30, 3, 2'b01, 3'd2, 4'hF, 1'b0, -1, 5, -1, "bstall_wr");

        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE0000 + 32'(i);
        axi_write(32'h1F8, 3, 2'b01, 3'd2, 4'hF, 1'b0, -1, 0, -1, "oob_wr");
        axi_read(32'h1F8, 3, 2'b01, 3'd2, 1, "oob_rd");

        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        axi_write(32'h10, 3, 2'b00, 3'd2, 4'hF, 1'b0, -1, 0, -1, "fixed_wr");
        axi_read(32'h10, 0, 2'b01, 3'd2, 0, "fixed_rd");
        check("fixed_value", last_rdata, 32'd4);
        axi_read(32'h10, 2, 2'b00, 3'd2, 1, "fixed_burst_rd");

        for (int i = 0; i < 4; i++) wbuf[i] = 32'hDEAD0000 + 32'(i);
        axi_write(32'h40, 3, 2'b10, 3'd2, 4'hF, 1'b0, -1, 0, -1, "wrap_wr");
        axi_read(32'h40, 3, 2'b10, 3'd2, 0, "wrap_rd");
        axi_read(32'h40, 3, 2'b01, 3'd2, 0, "wrap_check_rd");
        axi_write(32'h50, 1, 2'b01, 3'd1, 4'hF, 1'b0, -1, 0, -1, "size_wr");
        axi_read(32'h50, 1, 2'b01, 3'd1, 0, "size_rd");
        axi_write(32'h60, 3, 2'b01, 3'd2, 4'hF, 1'b0, 1, 0, -1, "early_wlast_wr");
        axi_write(32'h70, 2, 2'b01, 3'd2, 4'hF, 1'b0, 2, 0, -1, "missing_wlast_wr");
        axi_read(32'h60, 7, 2'b01, 3'd2, 1, "wlast_rd");

        for (int i = 0; i < 8; i++) wbuf[i] = 32'h5A5A0000 + 32'(i);
        axi_write(32'h80, 7, 2'b01, 3'd2, 4'hF, 1'b0, -1, 0, 2, "abort_wr");
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hA5A50000 + 32'(i);
        axi_write(32'h80, 7, 2'b01, 3'd2, 4'hF, 1'b0, -1, 1, -1, "post_reset_wr");
        axi_read(32'h80, 7, 2'b01, 3'd2, 1, "post_reset_rd");

        for (int n = 0; n < 16; n++) begin
            r_len   = int'($urandom_range(15));
            r_addr  = 32'($urandom_range(140)) << 2;
            r_pick  = int'($urandom_range(9));
            r_burst = (r_pick < 6) ? 2'b01 : (r_pick < 8) ? 2'b00 : 2'b10;
            for (int i = 0; i <= r_len; i++) wbuf[i] = $urandom;
            axi_write(r_addr, r_len, r_burst, 3'd2, 4'hF, 1'b1, -1,
                      int'($urandom_range(2)), -1, "rand_wr");
            axi_read(r_addr, r_len, r_burst, 3'd2, 2, "rand_rd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
